// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-and-add multiplier with a start/busy/done handshake.
// Operands are reduced to magnitudes at start, multiplied unsigned over WIDTH steps, and
// the sign is restored on the final edge, so the signed and unsigned paths share one datapath.
module seq_mult_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // Counter must hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : gWidthCheck
            $error("seq_mult_param: WIDTH must lie in 4..32");
        end
    endgenerate

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic               signedReg;
    logic               negReg;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [CW-1:0]      count;
    logic               doneReg;
    logic [2*WIDTH-1:0] resultReg;

    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic               negIn;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     stepSum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] productNeg;
    logic               lastStep;

    // Operand conditioning at start: magnitudes (the most negative value maps onto itself,
    // which is the correct unsigned magnitude 2^(WIDTH-1)) and the product sign.
    always_comb begin
        aMag  = a;
        bMag  = b;
        negIn = 1'b0;
        if (signed_mode) begin
            if (a[WIDTH-1]) aMag = ~a + WIDTH'(1);
            if (b[WIDTH-1]) bMag = ~b + WIDTH'(1);
            negIn = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // One shift-add step: the multiplier bit sits in accLo[0]; the carry is kept in the
    // extra sum bit and shifted down into accHi.
    always_comb begin
        addend     = accLo[0] ? {1'b0, magA} : '0;
        stepSum    = {1'b0, accHi} + addend;
        product    = {accHi, accLo};
        productNeg = ~product + (2 * WIDTH)'(1);
        lastStep   = (count == CW'(1));
    end

    // Next-state decode.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastStep) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation without touching done/result
    // beyond clearing them.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            signedReg <= 1'b0;
            negReg    <= 1'b0;
            magA      <= '0;
            accHi     <= '0;
            accLo     <= '0;
            count     <= '0;
            doneReg   <= 1'b0;
            resultReg <= '0;
        end else begin
            state   <= stateNext;
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        signedReg <= signed_mode;
                        negReg    <= negIn;
                        magA      <= aMag;
                        accHi     <= '0;
                        accLo     <= bMag;
                        count     <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    accHi <= stepSum[WIDTH:1];
                    accLo <= {stepSum[0], accLo[WIDTH-1:1]};
                    count <= count - CW'(1);
                end
                FIN: begin
                    resultReg <= (signedReg && negReg) ? productNeg : product;
                    doneReg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // busy covers RUN and FIN; it drops on the same edge that raises done.
    always_comb begin
        busy   = (state != IDLE);
        done   = doneReg;
        result = resultReg;
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: vector table, random operands against an
// arithmetic reference, and hand-written handshake/reset sequences on WIDTH=16 and WIDTH=8.
module tb_seq_mult_param;

    logic        clk;
    logic        r;
    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] result16;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;

    int nTests = 0;
    int nFail  = 0;

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .r(r), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16)
    );

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .r(r), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as integers of width w, multiply, keep 2w bits.
    function automatic logic [63:0] refMul(input logic [31:0] av, input logic [31:0] bv,
                                           input logic sm, input int w);
        longint x, y, p;
        x = longint'(av);
        y = longint'(bv);
        if (sm && av[w-1]) x = x - (longint'(1) << w);
        if (sm && bv[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Start one operation and follow it; doneAt is the cycle index after the start edge
    // at which done is seen (-1 if never).
    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                         output logic [31:0] res, output int doneAt, output int busyCnt,
                         output int doneCnt);
        @(negedge clk);
        a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        busyCnt = 0; doneCnt = 0; doneAt = -1; res = '0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (busy16) busyCnt++;
            if (done16) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt = k;
                    res = result16;
                end
            end
            if (doneAt >= 0 && k > doneAt) break;
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        output logic [15:0] res, output int doneAt);
        @(negedge clk);
        a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        doneAt = -1; res = '0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            if (done8 && doneAt < 0) begin
                doneAt = k;
                res = result8;
            end
            if (doneAt >= 0 && k > doneAt) break;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [15:0] res8;
        logic [31:0] expv;
        logic [63:0] full;
        logic [15:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic        rsm;
        int doneAt, busyCnt, doneCnt, extra;

        tbl[0] = '{16'h0007, 16'h0007, 1'b0, 32'h0000_0031};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
        tbl[3] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1};
        tbl[4] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000};
        tbl[6] = '{16'h0000, 16'h1234, 1'b0, 32'h0000_0000};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};

        r = 1'b0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy16), 64'd0);
        check("reset done", 64'(done16), 64'd0);
        check("reset result", 64'(result16), 64'd0);
        r = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run16(tbl[i].a, tbl[i].b, tbl[i].sm, res, doneAt, busyCnt, doneCnt);
            check($sformatf("vec%0d result", i), 64'(res), 64'(tbl[i].exp));
            check($sformatf("vec%0d done latency", i), 64'(doneAt), 64'd17);
            check($sformatf("vec%0d busy cycles", i), 64'(busyCnt), 64'd17);
            check($sformatf("vec%0d done pulses", i), 64'(doneCnt), 64'd1);
            check($sformatf("vec%0d result hold", i), 64'(result16), 64'(tbl[i].exp));
        end

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rsm = 1'($urandom);
            full = refMul(32'(ra), 32'(rb), rsm, 16);
            expv = 32'(full);
            run16(ra, rb, rsm, res, doneAt, busyCnt, doneCnt);
            check($sformatf("rand%0d %h*%h sm=%0d", i, ra, rb, rsm), 64'(res), 64'(expv));
            check($sformatf("rand%0d latency", i), 64'(doneAt), 64'd17);
        end

        // start during RUN must be ignored.
        @(negedge clk);
        a16 = 16'd100; b16 = 16'd200; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        doneAt = -1; extra = 0; res = '0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) begin
                start16 = 1'b1; a16 = 16'd9; b16 = 16'd9; sm16 = 1'b1;
            end else if (k == 6) begin
                start16 = 1'b0;
            end
            if (done16) begin
                if (doneAt < 0) begin
                    doneAt = k;
                    res = result16;
                end else begin
                    extra++;
                end
            end
        end
        check("ignore result", 64'(res), 64'd20000);
        check("ignore latency", 64'(doneAt), 64'd17);
        check("ignore no second done", 64'(extra), 64'd0);
        check("ignore result hold", 64'(result16), 64'd20000);

        // Back-to-back: new start in the done cycle.
        @(negedge clk);
        a16 = 16'd11; b16 = 16'd13; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        doneAt = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (done16) begin
                doneAt = k;
                break;
            end
        end
        check("b2b first latency", 64'(doneAt), 64'd17);
        check("b2b first result", 64'(result16), 64'd143);
        a16 = 16'd5; b16 = 16'd6; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("b2b second accepted", 64'(busy16), 64'd1);
        doneAt = -1; res = '0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 10) check("b2b result held", 64'(result16), 64'd143);
            if (done16) begin
                doneAt = k;
                res = result16;
                break;
            end
        end
        check("b2b second latency", 64'(doneAt), 64'd17);
        check("b2b second result", 64'(res), 64'd30);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a16 = 16'd1234; b16 = 16'd5678; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (8) @(negedge clk);
        #2 r = 1'b0;
        #1;
        check("abort busy", 64'(busy16), 64'd0);
        check("abort done", 64'(done16), 64'd0);
        check("abort result", 64'(result16), 64'd0);
        @(negedge clk);
        r = 1'b1;
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done16 || busy16) extra++;
        end
        check("abort no pending done", 64'(extra), 64'd0);
        run16(16'd3, 16'd4, 1'b0, res, doneAt, busyCnt, doneCnt);
        check("after abort result", 64'(res), 64'd12);
        check("after abort latency", 64'(doneAt), 64'd17);

        // WIDTH=8 instance.
        run8(8'hFF, 8'hFF, 1'b0, res8, doneAt);
        check("w8 255*255", 64'(res8), 64'h0000_FE01);
        check("w8 latency", 64'(doneAt), 64'd9);
        run8(8'h80, 8'h7F, 1'b1, res8, doneAt);
        check("w8 signed 80*7F", 64'(res8), 64'h0000_C080);
        check("w8 signed latency", 64'(doneAt), 64'd9);
        for (int i = 0; i < 20; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rsm = 1'($urandom);
            full = refMul(32'(ra8), 32'(rb8), rsm, 8);
            run8(ra8, rb8, rsm, res8, doneAt);
            check($sformatf("w8 rand%0d %h*%h sm=%0d", i, ra8, rb8, rsm), 64'(res8),
                  64'(16'(full)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential shift-and-add multiplier; next generation of the team's fixed 16-bit gate-level multiplier.
- Adds a generic operand width, a start/busy/done handshake, and a signed (two's-complement) mode.
- Sits as a multi-cycle arithmetic unit beside the datapath. A controller loads the operands, pulses start, and samples result when done pulses.

Parameters:
- WIDTH, 16, operand width in bits. Legal range is 4..32. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- r  input  1  reset; asynchronous and active-low.
- start  input  1  request a multiply; sampled only when busy=0.
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; captured with start.
- a  input  WIDTH  multiplicand; captured with start.
- b  input  WIDTH  multiplier; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  2*WIDTH  product of the last completed operation.

Behaviour:
- Reset (r=0, asynchronous): state goes to IDLE; busy=0, done=0, result=0; all internal registers are cleared. Reset in the middle of an operation aborts it and result does not update.
- FSM states: IDLE, RUN, FIN.
- IDLE: busy=0. On an edge with start=1:
  - capture signed_mode;
  - capture mag_a = |a| and mag_b = |b| when signed_mode=1, otherwise a and b as given;
  - capture neg = signed_mode & (a[MSB] ^ b[MSB]);
  - clear the accumulator and load the iteration counter with WIDTH;
  - go to RUN.
- Magnitudes are held as WIDTH-bit unsigned values. The most negative operand (e.g. 0x8000) has magnitude 2^(WIDTH-1), which fits.
- RUN: busy=1. Each edge performs one shift-add step:
  - if the multiplier LSB is 1, add mag_a to the upper accumulator half with a WIDTH+1-bit sum (carry kept);
  - shift {carry, acc_hi, acc_lo} right by one;
  - decrement the counter.
- RUN lasts exactly WIDTH edges, independent of operand values; there is no early termination. Go to FIN when the counter reaches 0.
- FIN: busy=1 for this cycle.
  - On the next edge, result <= neg ? (two's-complement negation of the accumulator) : accumulator.
  - On the same edge done <= 1, busy <= 0, and the state returns to IDLE.
- done is high for exactly one cycle, the cycle after the FIN edge.
- Latency: start sampled at edge 0, then RUN edges 1..WIDTH, then the FIN edge WIDTH+1. done and the new result are visible after edge WIDTH+1, i.e. WIDTH+1 cycles after start.
- start while busy=1 is ignored: no queueing, and the in-flight operands are unaffected.
- start may be asserted in the same cycle that done=1 (state IDLE). It is accepted and a new operation begins. result keeps its value until that operation's FIN edge.
- result holds the last product indefinitely. a, b and signed_mode may change freely after the start edge.
- Zero operands still take the full WIDTH+1 cycles.
- Signed products are exact in 2*WIDTH bits; no overflow is possible.
- Unsigned products are exact, including the all-ones operand case.

Test Plan:
- Reset then unsigned 7*7 (WIDTH=16), start for one cycle -> busy=1 for 17 cycles; done pulses once, 17 cycles after the start edge; result=0x00000031.
- Unsigned 0xFFFF*0xFFFF -> result=0xFFFE0001. Repeat with signed_mode=1 -> result=0x00000001 (-1*-1).
- Signed -3*5 (a=0xFFFD, b=0x0005) -> result=0xFFFFFFF1. Signed 0x8000*0x8000 -> result=0x40000000. Signed 0x8000*0x0001 -> result=0xFFFF8000.
- start pulsed again at cycle 5 of a run with different operands -> ignored; the original product is returned at the original time. A back-to-back start in the done cycle -> second product arrives 17 cycles later.
- Assert r=0 at cycle 8 of a run -> busy, done and result go to 0 immediately with no pending done. After release, a fresh 3*4 -> result=12.
- WIDTH=8 instance: unsigned 255*255 -> result=0xFE01 with done 9 cycles after start; signed 0x80*0x7F -> result=0xC080.
